// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch -> decode prefetch queue.
package fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pair_t;

    // Value presented on the decode side whenever no entry is valid.
    localparam fetch_pair_t EMPTY_PAIR = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue; master = fetch+decode side, slave = queue.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic [31:0]              in_pc;
    logic [31:0]              in_instr;
    logic                     in_ready;
    logic                     out_valid;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic                     out_ready;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue_storage.sv
// DEPTH-entry {pc, instr} register file: one synchronous write port, one async read port.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_pair_t   wdata,
    input  logic [AW-1:0] raddr,
    output fetch_pair_t   rdata
);

    fetch_pair_t mem [DEPTH];

    // Contents are qualified by the owner's count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode.
// Optional FETCH_QUEUE_BYPASS_EN: zero-latency passthrough while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    fetch_pair_t   in_pair, rd_pair, out_pair;
    logic          full, empty, in_ready, out_valid;
    logic          push, pop, wr_en, rd_en;

    assign in_pair  = fetch_pair_t'({q.in_pc, q.in_instr});
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

`ifdef FETCH_QUEUE_BYPASS_EN
    always_comb begin
        out_valid = !empty;
        out_pair  = empty ? EMPTY_PAIR : rd_pair;
        if (empty && q.in_valid && !q.flush) begin
            out_valid = 1'b1;
            out_pair  = in_pair;
        end
    end
`else
    always_comb begin
        out_valid = !empty;
        out_pair  = empty ? EMPTY_PAIR : rd_pair;
    end
`endif

    assign push = q.in_valid & in_ready & !q.flush;
    assign pop  = out_valid & q.out_ready & !q.flush;

    // A pop while empty can only be a bypassed pair: it never touches storage.
    assign wr_en = push & !(empty & pop);
    assign rd_en = pop & !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    fq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (in_pair),
        .raddr (rd_ptr),
        .rdata (rd_pair)
    );

    assign q.in_ready  = in_ready;
    assign q.out_valid = out_valid;
    assign q.out_pc    = out_pair.pc;
    assign q.out_instr = out_pair.instr;
    assign q.count     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

    fetch_queue_if #(.DEPTH(4)) q ();

    fetch_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        q.in_valid = v;
        q.in_pc    = pc;
        q.in_instr = instr;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0);
        q.out_ready = 1'b0;
        q.flush     = 1'b0;

        // reset state
        #12;
        chk("rst_count", 64'(q.count), 64'd0);
        chk("rst_out_valid", 64'(q.out_valid), 64'd0);
        chk("rst_in_ready", 64'(q.in_ready), 64'd1);
        chk("rst_out_pc", 64'(q.out_pc), 64'd0);
        chk("rst_out_instr", 64'(q.out_instr), 64'd0);
        reset = 1'b1;
        step();

        // two pushes with decode stalled, then in-order pops
        drive(1'b1, 32'h3000, 32'h2401_0001);
        step();
        chk("t1_count1", 64'(q.count), 64'd1);
        drive(1'b1, 32'h3004, 32'h2402_0002);
        step();
        chk("t1_count2", 64'(q.count), 64'd2);
        chk("t1_head_pc", 64'(q.out_pc), 64'h3000);
        chk("t1_head_instr", 64'(q.out_instr), 64'h2401_0001);
        drive(1'b0, 32'h0, 32'h0);
        q.out_ready = 1'b1;
        step();
        chk("t1_pop1_pc", 64'(q.out_pc), 64'h3004);
        chk("t1_pop1_instr", 64'(q.out_instr), 64'h2402_0002);
        chk("t1_pop1_count", 64'(q.count), 64'd1);
        step();
        chk("t1_empty_count", 64'(q.count), 64'd0);
        chk("t1_empty_valid", 64'(q.out_valid), 64'd0);
        chk("t1_empty_pc", 64'(q.out_pc), 64'd0);

        // fill to DEPTH, refuse a fifth pair, accept it after one pop
        q.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1));
            step();
        end
        chk("t2_full_count", 64'(q.count), 64'd4);
        chk("t2_full_in_ready", 64'(q.in_ready), 64'd0);
        drive(1'b1, 32'h110, 32'd5);
        step();
        chk("t2_refused_count", 64'(q.count), 64'd4);
        chk("t2_refused_head", 64'(q.out_pc), 64'h100);
        q.out_ready = 1'b1;
        step();
        chk("t2_pop_full_count", 64'(q.count), 64'd3);
        chk("t2_pop_full_in_ready", 64'(q.in_ready), 64'd1);
        chk("t2_pop_full_head", 64'(q.out_pc), 64'h104);
        q.out_ready = 1'b0;
        step();
        chk("t2_fifth_in_count", 64'(q.count), 64'd4);
        drive(1'b0, 32'h0, 32'h0);
        q.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_pc", 64'(q.out_pc), 64'h104 + 64'(4 * i));
            chk("t2_drain_instr", 64'(q.out_instr), 64'(i + 2));
            step();
        end
        chk("t2_drained", 64'(q.count), 64'd0);

        // streaming through pointer wrap with constant occupancy
        q.out_ready = 1'b0;
        drive(1'b1, 32'h3000, 32'hA000);
        step();
        q.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 32'hA000 + 32'(i));
            chk("t3_stream_pc", 64'(q.out_pc), 64'h3000 + 64'(4 * (i - 1)));
            step();
            chk("t3_stream_count", 64'(q.count), 64'd1);
        end
        chk("t3_tail_pc", 64'(q.out_pc), 64'h3028);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t3_drained", 64'(q.count), 64'd0);

        // flush with a concurrent push and pop
        q.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 32'hB000 + 32'(i));
            step();
        end
        chk("t4_pre_count", 64'(q.count), 64'd3);
        drive(1'b1, 32'h3010, 32'hB010);
        q.flush     = 1'b1;
        q.out_ready = 1'b1;
        step();
        q.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        q.out_ready = 1'b0;
        #1;
        chk("t4_flush_count", 64'(q.count), 64'd0);
        chk("t4_flush_valid", 64'(q.out_valid), 64'd0);
        drive(1'b1, 32'h4000, 32'hC000);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("t4_next_count", 64'(q.count), 64'd1);
        chk("t4_next_head", 64'(q.out_pc), 64'h4000);
        q.out_ready = 1'b1;
        step();
        chk("t4_drained", 64'(q.count), 64'd0);

        // asynchronous reset between edges
        q.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 32'(i));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        chk("t5_pre_count", 64'(q.count), 64'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_async_valid", 64'(q.out_valid), 64'd0);
        chk("t5_async_in_ready", 64'(q.in_ready), 64'd1);
        chk("t5_async_count", 64'(q.count), 64'd0);
        #1;
        reset = 1'b1;
        step();
        drive(1'b1, 32'h600, 32'hD00);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("t5_after_count", 64'(q.count), 64'd1);
        chk("t5_after_head", 64'(q.out_pc), 64'h600);
        q.out_ready = 1'b1;
        step();
        chk("t5_alone", 64'(q.out_valid), 64'd0);

        // empty queue with decode ready
        drive(1'b1, 32'h3000, 32'h8C08_0000);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("t6_byp_valid", 64'(q.out_valid), 64'd1);
        chk("t6_byp_pc", 64'(q.out_pc), 64'h3000);
        chk("t6_byp_instr", 64'(q.out_instr), 64'h8C08_0000);
        q.flush = 1'b1;
        #1;
        chk("t6_byp_flush", 64'(q.out_valid), 64'd0);
        q.flush = 1'b0;
        step();
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("t6_byp_count", 64'(q.count), 64'd0);
`else
        chk("t6_latency_valid", 64'(q.out_valid), 64'd0);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("t6_latency_pc", 64'(q.out_pc), 64'h3000);
        chk("t6_latency_instr", 64'(q.out_instr), 64'h8C08_0000);
        step();
        chk("t6_latency_count", 64'(q.count), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
